// File: rtl/shift_left_pkg.sv
// Shared constants and the shift-by-one helper for the shift_left ALU slice.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package shift_left_pkg;

    localparam int SHL_WIDTH_DEFAULT = 8;

    // Widest operand the helper function can carry; instances truncate to their own width.
    localparam int SHL_WIDTH_MAX = 64;

    // Shift left by one with a caller-chosen LSB fill. Operating at the maximum width
    // lets any narrower instance take the low WIDTH bits, which equal
    // {value[WIDTH-2:0], fill} for a zero-extended operand.
    function automatic logic [SHL_WIDTH_MAX-1:0] shl1(
        input logic [SHL_WIDTH_MAX-1:0] value,
        input logic                     fill
    );
        return {value[SHL_WIDTH_MAX-2:0], fill};
    endfunction

endpackage

// File: rtl/shift_left_core.sv
// Combinational shift-left-by-one: result, shifted-out MSB and zero flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the outputs follow the inputs continuously.
module shift_left_core
    import shift_left_pkg::*;
#(
    parameter int WIDTH = SHL_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] A,
    input  logic             fill,
    output logic [WIDTH-1:0] next_out,
    output logic             next_cout,
    output logic             next_zero
);

    // Reject widths the shift cannot represent.
    generate
        if (WIDTH < 2 || WIDTH > SHL_WIDTH_MAX) begin : g_bad_width
            $error("shift_left_core: WIDTH out of range");
        end
    endgenerate

    logic [SHL_WIDTH_MAX-1:0] a_ext;

    // Zero-extend the operand so the shared helper can be used at any legal width.
    always_comb begin
        a_ext = '0;
        a_ext[WIDTH-1:0] = A;
    end

    // Shifted value, dropped MSB and zero test on the value that will be registered.
    always_comb begin
        next_out  = WIDTH'(shl1(a_ext, fill));
        next_cout = A[WIDTH-1];
        next_zero = (next_out == '0);
    end

endmodule

// File: rtl/shift_left.sv
// Registered logical shift-left-by-one for the ALU result mux (optional rotate via SHIFTLEFT_ROTATE_EN).
// Latency: 1 cycle from en=1 at a rising clk edge to Out1/Cout/Zero.
// Backpressure: none; en=0 holds all outputs, async rst clears them (Zero=1).
module shift_left
    import shift_left_pkg::*;
#(
    parameter int WIDTH = SHL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef SHIFTLEFT_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Out1,
    output logic             Cout,
    output logic             Zero
);

    logic             fill;
    logic [WIDTH-1:0] next_out;
    logic             next_cout;
    logic             next_zero;

    // LSB fill: the old MSB when rotating, otherwise a plain logical shift.
`ifdef SHIFTLEFT_ROTATE_EN
    always_comb fill = rot ? A[WIDTH-1] : 1'b0;
`else
    always_comb fill = 1'b0;
`endif

    shift_left_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A         (A),
        .fill      (fill),
        .next_out  (next_out),
        .next_cout (next_cout),
        .next_zero (next_zero)
    );

    // Single enable-gated register stage; reset takes priority over a same-edge capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Out1 <= '0;
            Cout <= 1'b0;
            Zero <= 1'b1;
        end else if (en) begin
            Out1 <= next_out;
            Cout <= next_cout;
            Zero <= next_zero;
        end
    end

endmodule

// File: tb/tb_shift_left.sv
// Directed self-checking bench for shift_left (rotate checks added when SHIFTLEFT_ROTATE_EN is defined).
// Latency: checks sample 1 time unit after the rising edge.
// Backpressure: not applicable.
module tb_shift_left;

    logic       clk;
    logic       rst;
    logic       en;
`ifdef SHIFTLEFT_ROTATE_EN
    logic       rot;
`endif
    logic [7:0] A;
    logic [7:0] Out1;
    logic       Cout;
    logic       Zero;

    int compared;
    int mismatched;

    shift_left #(
        .WIDTH (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
`ifdef SHIFTLEFT_ROTATE_EN
        .rot  (rot),
`endif
        .A    (A),
        .Out1 (Out1),
        .Cout (Cout),
        .Zero (Zero)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all three outputs against hand-computed values.
    task automatic expect3(input string tag, input logic [7:0] o, input logic c, input logic z);
        check({tag, ".Out1"}, Out1, o);
        check({tag, ".Cout"}, {7'd0, Cout}, {7'd0, c});
        check({tag, ".Zero"}, {7'd0, Zero}, {7'd0, z});
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        en  = 1'b1;
        A   = 8'h55;
`ifdef SHIFTLEFT_ROTATE_EN
        rot = 1'b0;
`endif

        // Reset state with no clock edge seen yet.
        #2;
        expect3("reset_noclk", 8'h00, 1'b0, 1'b1);

        // Reset wins over en=1 at an edge.
        tick();
        expect3("reset_edge", 8'h00, 1'b0, 1'b1);

        // Basic shifts.
        rst = 1'b0;
        A   = 8'h02;
        tick();
        expect3("basic_2", 8'h04, 1'b0, 1'b0);
        A = 8'h00;
        tick();
        expect3("basic_0", 8'h00, 1'b0, 1'b1);

        // Carry-out and truncation to zero.
        A = 8'h81;
        tick();
        expect3("carry_81", 8'h02, 1'b1, 1'b0);
        A = 8'h80;
        tick();
        expect3("carry_80", 8'h00, 1'b1, 1'b1);

        // All ones.
        A = 8'hFF;
        tick();
        expect3("ones_ff", 8'hFE, 1'b1, 1'b0);

        // Reset asserted between edges clears immediately.
        #2;
        rst = 1'b1;
        #1;
        expect3("midop_reset", 8'h00, 1'b0, 1'b1);
        #1;
        rst = 1'b0;
        A   = 8'h01;
        tick();
        expect3("after_reset", 8'h02, 1'b0, 1'b0);

        // Hold with en=0 while the operand changes.
        A = 8'h21;
        tick();
        expect3("hold_load", 8'h42, 1'b0, 1'b0);
        en = 1'b0;
        A  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect3($sformatf("hold_%0d", i), 8'h42, 1'b0, 1'b0);
        end

        // Re-enable after the hold.
        en = 1'b1;
        A  = 8'h40;
        tick();
        expect3("reenable_40", 8'h80, 1'b0, 1'b0);

`ifdef SHIFTLEFT_ROTATE_EN
        // Rotate fills the LSB with the old MSB; rot=0 is a plain shift.
        rot = 1'b1;
        A   = 8'h81;
        tick();
        expect3("rot_81", 8'h03, 1'b1, 1'b0);
        A = 8'h80;
        tick();
        expect3("rot_80", 8'h01, 1'b1, 1'b0);
        rot = 1'b0;
        A   = 8'h81;
        tick();
        expect3("norot_81", 8'h02, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
